// File: rtl/cpu_control_unit.sv
// Multicycle Moore control unit for the 16-bit CPU: owns PC/IR and sequences RF, data memory and ALU.
// Build option: define CU_ILLEGAL_OP_HALT_EN to halt on undefined opcodes instead of treating them as NOOP.
module cpu_control_unit #(
    parameter int PC_W     = 7,
    parameter int D_ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [15:0]         instr,
    output logic [PC_W-1:0]     pc_addr,
    output logic [D_ADDR_W-1:0] d_addr,
    output logic                d_wr,
    output logic                rf_sel,
    output logic                rf_w_en,
    output logic [3:0]          rf_w_addr,
    output logic [3:0]          rf_ra_addr,
    output logic [3:0]          rf_rb_addr,
    output logic [1:0]          alu_sel,
    output logic                halted,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    typedef struct packed {
        logic [D_ADDR_W-1:0] d_addr;
        logic                d_wr;
        logic                rf_sel;
        logic                rf_w_en;
        logic [3:0]          w_addr;
        logic [3:0]          ra_addr;
        logic [3:0]          rb_addr;
        logic [1:0]          alu_sel;
        logic                halted;
    } ctl_t;

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    ctl_t            r_ctl;

    // Control word presented while sitting in state s with instruction ir.
    function automatic ctl_t ctl_for(input state_t s, input logic [15:0] ir);
        ctl_t c;
        c = '0;
        case (s)
            S_STORE: begin
                c.d_addr  = ir[D_ADDR_W-1:0];
                c.ra_addr = ir[11:8];
                c.d_wr    = 1'b1;
            end
            S_LOAD_A: c.d_addr = ir[D_ADDR_W-1:0];
            S_LOAD_B: begin
                c.d_addr  = ir[D_ADDR_W-1:0];
                c.w_addr  = ir[11:8];
                c.rf_w_en = 1'b1;
            end
            S_ADD, S_SUB: begin
                c.ra_addr = ir[11:8];
                c.rb_addr = ir[7:4];
                c.w_addr  = ir[3:0];
                c.rf_sel  = 1'b1;
                c.rf_w_en = 1'b1;
                c.alu_sel = (s == S_ADD) ? 2'b01 : 2'b10;
            end
            S_HALT:  c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:   w_next = start ? S_FETCH : S_INIT;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (r_ir[15:12])
                    4'h0:    w_next = S_NOOP;
                    4'h1:    w_next = S_STORE;
                    4'h2:    w_next = S_LOAD_A;
                    4'h3:    w_next = S_ADD;
                    4'h4:    w_next = S_SUB;
                    4'h5:    w_next = S_HALT;
`ifdef CU_ILLEGAL_OP_HALT_EN
                    default: w_next = S_HALT;
`else
                    default: w_next = S_NOOP;
`endif
                endcase
            end
            S_LOAD_A: w_next = S_LOAD_B;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state so they are glitch-free yet still
    // a pure function of (state, IR); IR is only reloaded on the way into DECODE,
    // where every control output is zero anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
            r_pc    <= '0;
            r_ir    <= '0;
            r_ctl   <= '0;
        end else begin
            r_state <= w_next;
            r_ctl   <= ctl_for(w_next, r_ir);
            if (r_state == S_FETCH) begin
                r_ir <= instr;
                r_pc <= r_pc + PC_W'(1);
            end
        end
    end

    assign pc_addr    = r_pc;
    assign d_addr     = r_ctl.d_addr;
    assign d_wr       = r_ctl.d_wr;
    assign rf_sel     = r_ctl.rf_sel;
    assign rf_w_en    = r_ctl.rf_w_en;
    assign rf_w_addr  = r_ctl.w_addr;
    assign rf_ra_addr = r_ctl.ra_addr;
    assign rf_rb_addr = r_ctl.rb_addr;
    assign alu_sel    = r_ctl.alu_sel;
    assign halted     = r_ctl.halted;
    assign state      = r_state;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: ROM model driven from pc_addr, per-scenario tasks with inline checks.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] instr;
    logic [6:0]  pc_addr;
    logic [7:0]  d_addr;
    logic        d_wr, rf_sel, rf_w_en, halted;
    logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state;
    logic [1:0]  alu_sel;

    logic [15:0] rom [0:127];
    int errors = 0;
    int checks = 0;

    // Snapshot of outputs seen in each state during the last measured instruction.
    logic [7:0] s_daddr [0:15];
    logic       s_dwr   [0:15];
    logic       s_rfsel [0:15];
    logic       s_wen   [0:15];
    logic [3:0] s_waddr [0:15];
    logic [3:0] s_ra    [0:15];
    logic [3:0] s_rb    [0:15];
    logic [1:0] s_alu   [0:15];
    logic       s_seen  [0:15];
    logic       both_hi;

    always #5 clk = ~clk;
    assign instr = rom[pc_addr];

    cpu_control_unit #(.PC_W(7), .D_ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
        .pc_addr(pc_addr), .d_addr(d_addr), .d_wr(d_wr), .rf_sel(rf_sel),
        .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr), .rf_ra_addr(rf_ra_addr),
        .rf_rb_addr(rf_rb_addr), .alu_sel(alu_sel), .halted(halted), .state(state)
    );

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    task automatic reset_and_start();
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge with state==FETCH; runs until the next FETCH or HALT.
    task automatic measure(output int cnt);
        cnt = 0;
        both_hi = 1'b0;
        for (int i = 0; i < 16; i++) s_seen[i] = 1'b0;
        do begin
            @(negedge clk);
            cnt++;
            s_seen[state]  = 1'b1;
            s_daddr[state] = d_addr;
            s_dwr[state]   = d_wr;
            s_rfsel[state] = rf_sel;
            s_wen[state]   = rf_w_en;
            s_waddr[state] = rf_w_addr;
            s_ra[state]    = rf_ra_addr;
            s_rb[state]    = rf_rb_addr;
            s_alu[state]   = alu_sel;
            if (rf_w_en && d_wr) both_hi = 1'b1;
        end while (state != 4'd1 && state != 4'd9 && cnt < 20);
    endtask

    task automatic test_reset();
        clear_rom();
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if ({pc_addr, d_wr, rf_w_en, halted, d_addr, alu_sel} !== '0) begin
            errors++; $display("FAIL reset_outputs pc=%0d d_wr=%b w_en=%b halted=%b exp all 0", pc_addr, d_wr, rf_w_en, halted);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (state !== 4'd0 || pc_addr !== 7'd0) begin
            errors++; $display("FAIL init_hold state=%0d pc=%0d exp 0/0", state, pc_addr);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL start_fetch state=%0d exp=1", state); end
        @(negedge clk);
        checks++; if (state !== 4'd2 || pc_addr !== 7'd1) begin
            errors++; $display("FAIL after_fetch state=%0d pc=%0d exp 2/1", state, pc_addr);
        end
    endtask

    task automatic test_load_store();
        int cnt;
        clear_rom();
        rom[0] = 16'h2A05;
        rom[1] = 16'h1A07;
        reset_and_start();
        measure(cnt);
        checks++; if (cnt !== 4) begin errors++; $display("FAIL load_cycles got=%0d exp=4", cnt); end
        checks++; if (!s_seen[4] || s_daddr[4] !== 8'h05 || s_wen[4] !== 1'b0) begin
            errors++; $display("FAIL load_a seen=%b d_addr=%h w_en=%b exp 1/05/0", s_seen[4], s_daddr[4], s_wen[4]);
        end
        checks++; if (!s_seen[5] || s_wen[5] !== 1'b1 || s_waddr[5] !== 4'hA || s_rfsel[5] !== 1'b0 || s_daddr[5] !== 8'h05 || s_dwr[5] !== 1'b0) begin
            errors++; $display("FAIL load_b seen=%b w_en=%b w_addr=%h sel=%b d_addr=%h d_wr=%b exp 1/1/a/0/05/0",
                               s_seen[5], s_wen[5], s_waddr[5], s_rfsel[5], s_daddr[5], s_dwr[5]);
        end
        measure(cnt);
        checks++; if (cnt !== 3) begin errors++; $display("FAIL store_cycles got=%0d exp=3", cnt); end
        checks++; if (!s_seen[6] || s_dwr[6] !== 1'b1 || s_daddr[6] !== 8'h07 || s_ra[6] !== 4'hA || s_wen[6] !== 1'b0 || s_alu[6] !== 2'b00) begin
            errors++; $display("FAIL store seen=%b d_wr=%b d_addr=%h ra=%h w_en=%b alu=%b exp 1/1/07/a/0/00",
                               s_seen[6], s_dwr[6], s_daddr[6], s_ra[6], s_wen[6], s_alu[6]);
        end
        checks++; if (both_hi !== 1'b0) begin errors++; $display("FAIL exclusive_en got=%b exp=0", both_hi); end
    endtask

    task automatic test_add_sub();
        int cnt;
        clear_rom();
        rom[0] = 16'h3123;
        rom[1] = 16'h4123;
        reset_and_start();
        measure(cnt);
        checks++; if (cnt !== 3) begin errors++; $display("FAIL add_cycles got=%0d exp=3", cnt); end
        checks++; if (!s_seen[7] || s_ra[7] !== 4'd1 || s_rb[7] !== 4'd2 || s_waddr[7] !== 4'd3 || s_alu[7] !== 2'b01 || s_wen[7] !== 1'b1 || s_rfsel[7] !== 1'b1) begin
            errors++; $display("FAIL add seen=%b ra=%0d rb=%0d w=%0d alu=%b w_en=%b sel=%b exp 1/1/2/3/01/1/1",
                               s_seen[7], s_ra[7], s_rb[7], s_waddr[7], s_alu[7], s_wen[7], s_rfsel[7]);
        end
        measure(cnt);
        checks++; if (cnt !== 3) begin errors++; $display("FAIL sub_cycles got=%0d exp=3", cnt); end
        checks++; if (!s_seen[8] || s_ra[8] !== 4'd1 || s_rb[8] !== 4'd2 || s_waddr[8] !== 4'd3 || s_alu[8] !== 2'b10 || s_wen[8] !== 1'b1 || s_dwr[8] !== 1'b0) begin
            errors++; $display("FAIL sub seen=%b ra=%0d rb=%0d w=%0d alu=%b w_en=%b d_wr=%b exp 1/1/2/3/10/1/0",
                               s_seen[8], s_ra[8], s_rb[8], s_waddr[8], s_alu[8], s_wen[8], s_dwr[8]);
        end
    endtask

    task automatic test_halt();
        int cnt;
        logic ok;
        clear_rom();
        rom[0] = 16'h5000;
        reset_and_start();
        measure(cnt);
        checks++; if (state !== 4'd9 || halted !== 1'b1 || cnt !== 2) begin
            errors++; $display("FAIL halt_entry state=%0d halted=%b cycles=%0d exp 9/1/2", state, halted, cnt);
        end
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            start = ~start;
            @(negedge clk);
            if (state !== 4'd9 || pc_addr !== 7'd1 || halted !== 1'b1) ok = 1'b0;
        end
        start = 1'b0;
        checks++; if (ok !== 1'b1) begin
            errors++; $display("FAIL halt_hold state=%0d pc=%0d halted=%b exp 9/1/1", state, pc_addr, halted);
        end
    endtask

    task automatic test_pc_wrap();
        int guard;
        clear_rom();
        reset_and_start();
        guard = 0;
        while (pc_addr !== 7'd127 && guard < 1000) begin @(negedge clk); guard++; end
        checks++; if (pc_addr !== 7'd127) begin errors++; $display("FAIL pc_reach_127 pc=%0d exp=127", pc_addr); end
        guard = 0;
        while (pc_addr !== 7'd0 && guard < 10) begin @(negedge clk); guard++; end
        checks++; if (pc_addr !== 7'd0 || state !== 4'd2) begin
            errors++; $display("FAIL pc_wrap pc=%0d state=%0d exp 0/2", pc_addr, state);
        end
    endtask

    task automatic test_illegal();
        int cnt;
        clear_rom();
        rom[0] = 16'hF000;
        reset_and_start();
        measure(cnt);
`ifdef CU_ILLEGAL_OP_HALT_EN
        checks++; if (state !== 4'd9 || halted !== 1'b1 || pc_addr !== 7'd1) begin
            errors++; $display("FAIL illegal_halt state=%0d halted=%b pc=%0d exp 9/1/1", state, halted, pc_addr);
        end
`else
        checks++; if (!s_seen[3] || cnt !== 3 || state !== 4'd1 || halted !== 1'b0) begin
            errors++; $display("FAIL illegal_noop seen_noop=%b cycles=%0d state=%0d halted=%b exp 1/3/1/0",
                               s_seen[3], cnt, state, halted);
        end
`endif
    endtask

    task automatic test_reset_mid_load();
        int guard;
        logic pulse;
        clear_rom();
        rom[0] = 16'h2A05;
        reset_and_start();
        guard = 0;
        while (state !== 4'd4 && guard < 10) begin @(negedge clk); guard++; end
        checks++; if (state !== 4'd4) begin errors++; $display("FAIL reach_load_a state=%0d exp=4", state); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (state !== 4'd0 || rf_w_en !== 1'b0 || d_addr !== 8'h00) begin
            errors++; $display("FAIL async_reset state=%0d w_en=%b d_addr=%h exp 0/0/00", state, rf_w_en, d_addr);
        end
        pulse = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rf_w_en !== 1'b0 || state !== 4'd0) pulse = 1'b1;
        end
        rst_n = 1'b1;
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL no_commit got_pulse=%b exp=0", pulse); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clear_rom();
        test_reset();
        test_load_store();
        test_add_sub();
        test_halt();
        test_pc_wrap();
        test_illegal();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
